seq_shift_add_multiplier: RTL and testbench

//  Self-contained iterative multiplier: integrated controller + datapath, radix-2 shift-and-add.

---
 rtl/seq_shift_add_multiplier.sv | 131 +++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_shift_add_multiplier: iterative radix-2 shift-and-add multiplier with    |
// | signed/unsigned mode, optional early exit and start/busy/done handshake.     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module seq_shift_add_multiplier #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_q,   state_d;
  logic [PW-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q,     acc_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic            neg_q,     neg_d;
  logic [PW-1:0]   product_q, product_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] mplier_shr;
  logic [CW-1:0]    cnt_dec;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is exactly
  // the correct magnitude when read back as unsigned.
  always_comb begin
    a_mag = (signed_mode && a_in[WIDTH-1]) ? (~a_in + WIDTH'(1)) : a_in;
    b_mag = (signed_mode && b_in[WIDTH-1]) ? (~b_in + WIDTH'(1)) : b_in;
  end

  always_comb begin
    mplier_shr = mplier_q >> 1;
    cnt_dec    = cnt_q - CW'(1);
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          neg_d    = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          cnt_d    = CW'(WIDTH);
          state_d  = ST_CALC;
        end
      end

      ST_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_dec;
        if ((cnt_dec == '0) || (EARLY_EXIT && (mplier_shr == '0))) begin
          state_d = ST_FIXUP;
        end
      end

      ST_FIXUP: begin
        // A zero accumulator negates to zero, so no special case is needed.
        product_d = neg_q ? ('0 - acc_q) : acc_q;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_shift_add_multiplier: drives a full-length and an early-exit instance |
// | side by side against an arithmetic reference. Revision: 1.0                  |
// +----------------------------------------------------------------------------+
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start0 = 1'b0;
  logic         start1 = 1'b0;
  logic         sm = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2*W-1:0] product0, product1;
  logic         busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm),
    .a_in(a), .b_in(b), .product(product0), .busy(busy0), .done(done0)
  );

  seq_shift_add_multiplier #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm),
    .a_in(a), .b_in(b), .product(product1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation on both instances; optionally hammer start while busy.
  task automatic run_op(input logic smi, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input bit hammer);
    logic [2*W-1:0] exp_p;
    logic [2*W-1:0] prev0, prev1;
    int mag, iters, lat0, lat1, n0, n1;
    bit stable;

    if (smi) exp_p = 16'($signed({{W{ai[W-1]}}, ai}) * $signed({{W{bi[W-1]}}, bi}));
    else     exp_p = {{W{1'b0}}, ai} * {{W{1'b0}}, bi};
    mag = (smi && bi[W-1]) ? (256 - int'(bi)) : int'(bi);
    iters = 0;
    while (mag > 0) begin
      iters++;
      mag = mag >> 1;
    end
    if (iters == 0) iters = 1;

    prev0 = product0;
    prev1 = product1;
    @(negedge clk);
    sm = smi; a = ai; b = bi;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1;
    lat0 = 0; lat1 = 0; n0 = 0; n1 = 0; stable = 1'b1;
    for (int c = 1; c <= W + 6; c++) begin
      start0 = hammer && busy0;
      start1 = hammer && busy1;
      if (hammer) begin
        a  = W'($urandom_range(255));
        b  = W'($urandom_range(255));
        sm = 1'($urandom_range(1));
      end
      @(posedge clk);
      #1;
      if (done0) begin n0++; if (lat0 == 0) lat0 = c; end
      if (done1) begin n1++; if (lat1 == 0) lat1 = c; end
      if (lat0 == 0 && product0 !== prev0) stable = 1'b0;
      if (lat1 == 0 && product1 !== prev1) stable = 1'b0;
    end
    start0 = 1'b0; start1 = 1'b0;

    chk("product_full", 32'(product0), 32'(exp_p));
    chk("product_early", 32'(product1), 32'(exp_p));
    chk("latency_full", lat0, W + 1);
    chk("latency_early", lat1, iters + 1);
    chk("done_count_full", n0, 1);
    chk("done_count_early", n1, 1);
    chk("product_held_while_busy", 32'(stable), 32'd1);
    chk("idle_after_op", {30'd0, busy0, busy1}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {30'd0, busy0, busy1}, 32'd0);
    chk("reset_done", {30'd0, done0, done1}, 32'd0);
    chk("reset_product", {product0, product1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 8'd13,  8'd11,  1'b0);
    run_op(1'b0, 8'd255, 8'd255, 1'b0);
    run_op(1'b1, 8'd255, 8'd255, 1'b0);
    run_op(1'b1, 8'd253, 8'd5,   1'b0);
    run_op(1'b1, 8'h80,  8'h80,  1'b0);
    run_op(1'b1, 8'h80,  8'h7F,  1'b0);
    run_op(1'b0, 8'd77,  8'd0,   1'b0);
    run_op(1'b1, 8'hF0,  8'd0,   1'b0);
    run_op(1'b0, 8'd0,   8'hC3,  1'b0);
    run_op(1'b1, 8'd0,   8'hFF,  1'b0);
    run_op(1'b0, 8'd200, 8'd3,   1'b0);
    run_op(1'b0, 8'd9,   8'h80,  1'b0);

    // Start held high throughout each operation with changing operands.
    run_op(1'b0, 8'd21, 8'd6, 1'b1);
    run_op(1'b1, 8'hE7, 8'd100, 1'b1);

    // Reset while iterating aborts both instances.
    @(negedge clk);
    sm = 1'b0; a = 8'd99; b = 8'hFF;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {30'd0, busy0, busy1}, 32'd0);
    chk("abort_done", {30'd0, done0, done1}, 32'd0);
    chk("abort_product", {product0, product1}, 32'd0);
    rst = 1'b0;
    run_op(1'b1, 8'd250, 8'd7, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op(1'($urandom_range(1)), W'($urandom_range(255)), W'($urandom_range(255)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
